reg_write_demux: RTL and testbench

REG_WRITE_DEMUX -- requirements
Module: reg_write_demux

---
 rtl/reg_write_demux.sv | 80 ++++++++
 tb/tb_reg_write_demux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_demux.sv
// Register-file writeback demux with an issue/writeback pending scoreboard.
// Define REG_WRITE_DEMUX_STALE_CHECK_EN to enable the sticky stale-write detector.
module reg_write_demux #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [4:0]        issue_addr,
  output logic [31:0]       out_en,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       pending,
  output logic [5:0]        pend_cnt,
  output logic              stale_err
);

  // Handshake: wr_en and issue_en are plain valids with no ready; the block
  // accepts every request on every non-reset cycle.
  localparam logic [4:0] ZERO_REG = 5'd31;

  logic        wr_live;
  logic        issue_live;
  logic [31:0] wr_onehot;
  logic [31:0] issue_onehot;
  logic [31:0] pending_next;
  logic [5:0]  cnt_next;

  assign wr_live    = wr_en && (wr_addr != ZERO_REG);
  assign issue_live = issue_en && (issue_addr != ZERO_REG);

  always_comb begin
    wr_onehot    = '0;
    issue_onehot = '0;
    if (wr_live) wr_onehot[wr_addr] = 1'b1;
    if (issue_live) issue_onehot[issue_addr] = 1'b1;
    // Clear before set so a same-cycle issue to the written register wins.
    pending_next     = (pending & ~wr_onehot) | issue_onehot;
    pending_next[31] = 1'b0;
    // Count the next value so pend_cnt tracks pending with no added latency.
    cnt_next = '0;
    for (int i = 0; i < 32; i++) begin
      cnt_next = cnt_next + 6'(pending_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_en   <= '0;
      out_data <= '0;
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      out_en <= wr_onehot;
      if (wr_en) out_data <= wr_data;
      pending  <= pending_next;
      pend_cnt <= cnt_next;
    end
  end

`ifdef REG_WRITE_DEMUX_STALE_CHECK_EN
  logic stale_q;

  // Uses the pre-update scoreboard, so a same-cycle issue does not mask it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stale_q <= 1'b0;
    end else if (wr_live && !pending[wr_addr]) begin
      stale_q <= 1'b1;
    end
  end

  assign stale_err = stale_q;
`else
  assign stale_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_demux.sv
// Bench for reg_write_demux: directed literal cases plus randomized traffic
// compared every cycle against a per-register array model.
module tb_reg_write_demux;

  localparam int DW = 64;

`ifdef REG_WRITE_DEMUX_STALE_CHECK_EN
  localparam bit STALE_ON = 1'b1;
`else
  localparam bit STALE_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [4:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          issue_en = 1'b0;
  logic [4:0]    issue_addr = '0;
  logic [31:0]   out_en;
  logic [DW-1:0] out_data;
  logic [31:0]   pending;
  logic [5:0]    pend_cnt;
  logic          stale_err;

  always #5 clk = ~clk;

  reg_write_demux #(.DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .out_en     (out_en),
    .out_data   (out_data),
    .pending    (pending),
    .pend_cnt   (pend_cnt),
    .stale_err  (stale_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_pend[32];
  logic [31:0]   m_out_en = '0;
  logic [DW-1:0] m_data = '0;
  bit            m_stale = 1'b0;
  bit            model_ok = 1'b0;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_out_en = '0;
      m_data   = '0;
      m_stale  = 1'b0;
      exp_q.delete();
      model_ok = 1'b1;
    end else begin
      m_out_en = '0;
      if (wr_en) exp_q.push_back(wr_data);
      if (wr_en && wr_addr != 5'd31) begin
        m_out_en = 32'd1 << wr_addr;
        if (STALE_ON && !m_pend[wr_addr]) m_stale = 1'b1;
        m_pend[wr_addr] = 1'b0;
      end
      if (issue_en && issue_addr != 5'd31) m_pend[issue_addr] = 1'b1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      logic [31:0] exp_vec;
      int          exp_cnt;
      exp_vec = '0;
      exp_cnt = 0;
      for (int i = 0; i < 32; i++) begin
        if (m_pend[i]) begin
          exp_vec[i] = 1'b1;
          exp_cnt++;
        end
      end
      if (exp_q.size() > 0) m_data = exp_q.pop_front();
      check("out_en", 64'(out_en), 64'(m_out_en));
      check("out_data", 64'(out_data), 64'(m_data));
      check("pending", 64'(pending), 64'(exp_vec));
      check("pend_cnt", 64'(pend_cnt), 64'(exp_cnt));
      check("stale_err", 64'(stale_err), 64'(m_stale));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    issue_en = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drive(input bit we, input logic [4:0] wa, input logic [DW-1:0] wd,
                       input bit ie, input logic [4:0] ia);
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    issue_en   = ie;
    issue_addr = ia;
    tick();
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick();
    do_reset();
    check("rst_out_en", 64'(out_en), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_pending", 64'(pending), 64'h0);
    check("rst_pend_cnt", 64'(pend_cnt), 64'h0);
    check("rst_stale", 64'(stale_err), 64'h0);

    // Basic writeback decode
    drive(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0);
    check("wb5_out_en", 64'(out_en), 64'h20);
    check("wb5_out_data", 64'(out_data), 64'hDEAD);
    tick();
    check("wb5_out_en_next", 64'(out_en), 64'h0);
    check("wb5_data_hold", 64'(out_data), 64'hDEAD);

    // Two issues then one writeback
    do_reset();
    drive(1'b0, 5'd0, '0, 1'b1, 5'd3);
    drive(1'b0, 5'd0, '0, 1'b1, 5'd7);
    check("iss_pending", 64'(pending), 64'h88);
    check("iss_cnt", 64'(pend_cnt), 64'd2);
    drive(1'b1, 5'd3, 64'h1, 1'b0, 5'd0);
    check("wb3_pending", 64'(pending), 64'h80);
    check("wb3_cnt", 64'(pend_cnt), 64'd1);

    // Same-cycle issue and writeback to one register: issue wins
    do_reset();
    drive(1'b0, 5'd0, '0, 1'b1, 5'd9);
    drive(1'b1, 5'd9, 64'h99, 1'b1, 5'd9);
    check("same9_pending", 64'(pending), 64'h200);
    check("same9_out_en", 64'(out_en), 64'h200);
    check("same9_stale", 64'(stale_err), 64'h0);

    // Zero register is inert
    drive(1'b1, 5'd31, 64'h31, 1'b1, 5'd31);
    check("zr_out_en", 64'(out_en), 64'h0);
    check("zr_pending", 64'(pending), 64'h200);
    check("zr_stale", 64'(stale_err), 64'h0);

    // Stale writeback, sticky until reset
    do_reset();
    drive(1'b1, 5'd4, 64'h4, 1'b0, 5'd0);
    check("stale_set", 64'(stale_err), 64'(STALE_ON));
    check("stale_out_en", 64'(out_en), 64'h10);
    repeat (3) tick();
    check("stale_sticky", 64'(stale_err), 64'(STALE_ON));

    // Fill the scoreboard, then reset with a writeback in the reset cycle
    do_reset();
    for (int r = 0; r < 31; r++) drive(1'b0, 5'd0, '0, 1'b1, 5'(r));
    check("full_pending", 64'(pending), 64'h7FFF_FFFF);
    check("full_cnt", 64'(pend_cnt), 64'd31);
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd2;
    wr_data = 64'h2222;
    tick();
    reset = 1'b0;
    idle();
    check("rstwb_pending", 64'(pending), 64'h0);
    tick();
    check("post_rst_out_en", 64'(out_en), 64'h0);
    check("post_rst_pending", 64'(pending), 64'h0);
    check("post_rst_cnt", 64'(pend_cnt), 64'h0);
    check("post_rst_data", 64'(out_data), 64'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = 5'($urandom_range(0, 31));
      wr_data    = {$urandom(), $urandom()};
      issue_en   = 1'($urandom_range(0, 1));
      issue_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      tick();
    end
    idle();
    reset = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
